// File: rtl/mdu.sv
// mdu: iterative radix-2 RV32M multiply/divide unit, one result bit per cycle.
// Define MDU_DIV_EN to build the divider; otherwise ops 4-7 complete at once with 0.
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            mdu_valid_i,
    output logic            mdu_ready_o,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_data1_i,
    input  logic [XLEN-1:0] mdu_data2_i,
    input  logic            mdu_flush_i,
    output logic            mdu_valid_o,
    input  logic            mdu_ready_i,
    output logic [XLEN-1:0] mdu_data_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mcand_q;

    logic                accept, is_div, sgn1, sgn2, s1, s2, special;
    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic [XLEN-1:0]     abs1, abs2, special_res, res_d;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   acc_nxt, prod_fix;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign mdu_ready_o = (state_q == IDLE);
    assign mdu_valid_o = (state_q == DONE);
    assign accept      = mdu_valid_i & mdu_ready_o & ~mdu_flush_i;
    assign is_div      = mdu_op_i[2];

    // Operand signedness by funct3: MULHU/DIVU/REMU unsigned, MULHSU only rs1 signed
    assign sgn1  = (mdu_op_i != 3'd3) && (mdu_op_i != 3'd5) && (mdu_op_i != 3'd7);
    assign sgn2  = (mdu_op_i == 3'd0) || (mdu_op_i == 3'd1) ||
                   (mdu_op_i == 3'd4) || (mdu_op_i == 3'd6);
    assign rs1_s = mdu_data1_i;
    assign rs2_s = mdu_data2_i;
    assign s1    = sgn1 && (rs1_s < 0);
    assign s2    = sgn2 && (rs2_s < 0);
    assign abs1  = neg_if(mdu_data1_i, s1);
    assign abs2  = neg_if(mdu_data2_i, s2);

`ifdef MDU_DIV_EN
    logic                rneg_q;
    logic [XLEN:0]       rem_q, rem_nxt;
    logic [XLEN-1:0]     quo_q, dvsr_q, quo_nxt;
    logic [XLEN+1:0]     diff;
    logic                qbit, div0, ovf;

    assign div0 = is_div && (mdu_data2_i == '0);
    assign ovf  = is_div && !mdu_op_i[0] &&
                  (mdu_data1_i == {1'b1, {(XLEN-1){1'b0}}}) && (mdu_data2_i == '1);
    assign special = div0 | ovf;

    always_comb begin
        special_res = '0;
        if (div0)
            special_res = mdu_op_i[1] ? mdu_data1_i : '1;
        else
            special_res = mdu_op_i[1] ? '0 : mdu_data1_i;
    end

    // Restoring step: shift in next dividend bit, subtract divisor if it fits
    assign diff    = {rem_q, quo_q[XLEN-1]} - {2'b00, dvsr_q};
    assign qbit    = ~diff[XLEN+1];
    assign rem_nxt = qbit ? diff[XLEN:0] : {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign quo_nxt = {quo_q[XLEN-2:0], qbit};
`else
    assign special     = is_div;
    assign special_res = '0;
`endif

    // Shift-add step: conditionally add multiplicand to the upper half, then shift right
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fix = neg_wide(acc_nxt, neg_q);

    always_comb begin
        res_d = '0;
        case (op_q)
            3'd0:             res_d = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: res_d = prod_fix[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
            3'd4, 3'd5:       res_d = neg_if(quo_nxt, neg_q);
            default:          res_d = neg_if(rem_nxt[XLEN-1:0], rneg_q);
`else
            default:          res_d = '0;
`endif
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (mdu_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (mdu_flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            op_q       <= '0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mdu_data_o <= '0;
`ifdef MDU_DIV_EN
            rneg_q     <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
`endif
        end else if (state_q == IDLE) begin
            if (accept) begin
                op_q    <= mdu_op_i;
                neg_q   <= s1 ^ s2;
                cnt_q   <= CW'(XLEN - 1);
                acc_q   <= {{XLEN{1'b0}}, abs2};
                mcand_q <= abs1;
`ifdef MDU_DIV_EN
                rneg_q  <= s1;
                rem_q   <= '0;
                quo_q   <= abs1;
                dvsr_q  <= abs2;
`endif
                if (special)
                    mdu_data_o <= special_res;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - 1'b1;
            acc_q <= acc_nxt;
`ifdef MDU_DIV_EN
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
`endif
            if ((cnt_q == '0) && !mdu_flush_i)
                mdu_data_o <= res_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized and directed checks of mdu against a plain-arithmetic RV32M model.
module tb_mdu;
    logic        clk = 1'b0;
    logic        rst_n_i, mdu_valid_i, mdu_ready_o, mdu_flush_i, mdu_valid_o, mdu_ready_i;
    logic [2:0]  mdu_op_i;
    logic [31:0] mdu_data1_i, mdu_data2_i, mdu_data_o;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mdu #(.XLEN(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
        .mdu_op_i(mdu_op_i), .mdu_data1_i(mdu_data1_i), .mdu_data2_i(mdu_data2_i),
        .mdu_flush_i(mdu_flush_i), .mdu_valid_o(mdu_valid_o),
        .mdu_ready_i(mdu_ready_i), .mdu_data_o(mdu_data_o)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
`ifdef MDU_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_DIV_EN
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        return 33;
`else
        if (op[2] || a === 32'hx || b === 32'hx) return 1;
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present one request, wait (bounded) for the result, then consume it.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit zl, output logic [31:0] res, output int lat);
        int guard = 0;
        while (!mdu_ready_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        mdu_valid_i = 1'b1;
        mdu_op_i    = op;
        mdu_data1_i = a;
        mdu_data2_i = b;
        @(posedge clk); #1;
        mdu_valid_i = 1'b0;
        mdu_op_i    = 3'($urandom);
        mdu_data1_i = $urandom;
        mdu_data2_i = $urandom;
        mdu_ready_i = zl;
        lat = 1;
        while (!mdu_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = mdu_data_o;
        mdu_ready_i = 1'b1;
        @(posedge clk); #1;
        mdu_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; mdu_valid_i = 1'b0; mdu_ready_i = 1'b0; mdu_flush_i = 1'b0;
        mdu_op_i = 3'd0; mdu_data1_i = 32'h0; mdu_data2_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        checks++; if (mdu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", mdu_ready_o); end
        checks++; if (mdu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mdu_valid_o); end
        checks++; if (mdu_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mdu_data_o); end
        @(posedge clk); #1;
        checks++; if (mdu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_hold: got %b want 1", mdu_ready_o); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
        logic [31:0] as  [4] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex  [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, res, lat);
            checks++; if (res !== ex[i]) begin errors++; $display("FAIL mul_data op=%0d: got %h want %h", ops[i], res, ex[i]); end
            checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency op=%0d: got %0d want 33", ops[i], lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                 32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef MDU_DIV_EN
        logic [31:0] ex  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        int          el  [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
`else
        logic [31:0] ex  [8] = '{default: 32'd0};
        int          el  [8] = '{default: 1};
`endif
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], 1'b0, res, lat);
            checks++; if (res !== ex[i]) begin errors++; $display("FAIL div_data #%0d: got %h want %h", i, res, ex[i]); end
            checks++; if (lat !== el[i]) begin errors++; $display("FAIL div_latency #%0d: got %0d want %0d", i, lat, el[i]); end
        end
`ifndef MDU_DIV_EN
        do_op(3'd4, 32'd10, 32'd2, 1'b0, res, lat);
        checks++; if (res !== 32'd0 || lat !== 1) begin errors++; $display("FAIL nodiv_div: got %h lat %0d want 0 lat 1", res, lat); end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int lat;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, 1'b0, res, lat);
            checks++;
            if (res !== model(op, a, b)) begin
                errors++; $display("FAIL rand_data op=%0d a=%h b=%h: got %h want %h", op, a, b, res, model(op, a, b));
            end
            checks++;
            if (lat !== model_lat(op, a, b)) begin
                errors++; $display("FAIL rand_latency op=%0d: got %0d want %0d", op, lat, model_lat(op, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        do_op(3'd0, 32'd1000, 32'd3000, 1'b1, res, lat);
        checks++; if (res !== 32'd3000000 || lat !== 33) begin errors++; $display("FAIL b2b_first: got %h lat %0d want %h lat 33", res, lat, 32'd3000000); end
        checks++; if (mdu_ready_o !== 1'b1 || mdu_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready %b valid %b want 1 0", mdu_ready_o, mdu_valid_o); end
        do_op(3'd1, 32'hFFFF0000, 32'h00030000, 1'b1, res, lat);
        checks++; if (res !== model(3'd1, 32'hFFFF0000, 32'h00030000)) begin errors++; $display("FAIL b2b_second: got %h want %h", res, model(3'd1, 32'hFFFF0000, 32'h00030000)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, d;
        int lat = 0;
        a = $urandom; b = $urandom;
        mdu_valid_i = 1'b1; mdu_op_i = 3'd1; mdu_data1_i = a; mdu_data2_i = b;
        @(posedge clk); #1;
        mdu_valid_i = 1'b0;
        while (!mdu_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
        d = mdu_data_o;
        checks++; if (d !== model(3'd1, a, b)) begin errors++; $display("FAIL bp_data: got %h want %h", d, model(3'd1, a, b)); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (mdu_valid_o !== 1'b1 || mdu_data_o !== d) begin
                errors++; $display("FAIL bp_hold cycle %0d: valid %b data %h want 1 %h", i, mdu_valid_o, mdu_data_o, d);
            end
        end
        mdu_ready_i = 1'b1;
        @(posedge clk); #1;
        mdu_ready_i = 1'b0;
        checks++; if (mdu_valid_o !== 1'b0 || mdu_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b want 0 1", mdu_valid_o, mdu_ready_o); end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        bit seen;
        int lat = 0;
        prev = mdu_data_o;
        mdu_valid_i = 1'b1; mdu_op_i = 3'd0; mdu_data1_i = 32'h1234; mdu_data2_i = 32'h5678;
        @(posedge clk); #1;
        mdu_valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        mdu_flush_i = 1'b1;
        @(posedge clk); #1;
        mdu_flush_i = 1'b0;
        checks++; if (mdu_ready_o !== 1'b1 || mdu_valid_o !== 1'b0) begin errors++; $display("FAIL flush_calc: ready %b valid %b want 1 0", mdu_ready_o, mdu_valid_o); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (mdu_valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got valid want none"); end
        checks++; if (mdu_data_o !== prev) begin errors++; $display("FAIL flush_data: got %h want %h", mdu_data_o, prev); end

        mdu_flush_i = 1'b1; mdu_valid_i = 1'b1; mdu_op_i = 3'd0; mdu_data1_i = 32'd2; mdu_data2_i = 32'd3;
        @(posedge clk); #1;
        mdu_flush_i = 1'b0; mdu_valid_i = 1'b0;
        checks++; if (mdu_ready_o !== 1'b1) begin errors++; $display("FAIL flush_accept_ready: got %b want 1", mdu_ready_o); end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (mdu_valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_accept_valid: got valid want none"); end

        mdu_valid_i = 1'b1; mdu_op_i = 3'd0; mdu_data1_i = 32'd6; mdu_data2_i = 32'd7;
        @(posedge clk); #1;
        mdu_valid_i = 1'b0;
        while (!mdu_valid_o && lat < 100) begin @(posedge clk); #1; lat++; end
        mdu_flush_i = 1'b1;
        @(posedge clk); #1;
        mdu_flush_i = 1'b0;
        checks++; if (mdu_valid_o !== 1'b0 || mdu_ready_o !== 1'b1) begin errors++; $display("FAIL flush_done: valid %b ready %b want 0 1", mdu_valid_o, mdu_ready_o); end
        checks++; if (mdu_data_o !== 32'd42) begin errors++; $display("FAIL flush_done_data: got %h want %h", mdu_data_o, 32'd42); end
    endtask

    task automatic test_reset_mid_calc();
        logic [31:0] res;
        int lat;
        bit seen = 1'b0;
        mdu_valid_i = 1'b1; mdu_op_i = 3'd3; mdu_data1_i = 32'hDEADBEEF; mdu_data2_i = 32'h12345678;
        @(posedge clk); #1;
        mdu_valid_i = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        rst_n_i = 1'b0;
        @(posedge clk); #1;
        checks++; if (mdu_ready_o !== 1'b1 || mdu_valid_o !== 1'b0 || mdu_data_o !== 32'h0) begin
            errors++; $display("FAIL rst_mid: ready %b valid %b data %h want 1 0 0", mdu_ready_o, mdu_valid_o, mdu_data_o);
        end
        rst_n_i = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (mdu_valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid: got valid want none"); end
        do_op(3'd0, 32'd6, 32'd7, 1'b0, res, lat);
        checks++; if (res !== 32'd42 || lat !== 33) begin errors++; $display("FAIL rst_recover: got %h lat %0d want 2a lat 33", res, lat); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
